// File: rtl/mem_lsu_if.sv
// Pipeline-side and data-memory-side signals of the memory-stage load/store unit.
// master = the LSU itself, slave = pipeline/memory environment driving it.
interface mem_lsu_if;
    logic        valid_in;
    logic [5:0]  OP_code;
    logic [31:0] aluoutpu;
    logic [31:0] B;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] LMD;
    logic        valid_out;
    logic        stall;
    logic        misalign;
    logic        mem_err;

    modport master (
        input  valid_in, OP_code, aluoutpu, B, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, LMD, valid_out, stall, misalign, mem_err
    );

    modport slave (
        output valid_in, OP_code, aluoutpu, B, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, LMD, valid_out, stall, misalign, mem_err
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: registered single-beat lw/sw requests, LMD register, pipeline stall.
// Define MEM_LSU_TIMEOUT_EN to abort a request after TIMEOUT cycles without ack (mem_err pulse).
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_lsu_if.master bus
);
    // state | meaning
    // IDLE  | waiting for a MEM-stage lw/sw; misaligned ops only pulse misalign
    // REQ   | request outstanding, pipeline frozen until mem_ack
    // DONE  | op complete, valid_out pulse, stall released
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    generate
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("mem_lsu: TIMEOUT must be at least 2");
        end
    endgenerate

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] lmd_q;
    logic        valid_out_q;
    logic        misalign_q;

    logic is_mem;
    logic aligned;

    assign is_mem  = bus.valid_in && (bus.OP_code == OP_LW || bus.OP_code == OP_SW);
    assign aligned = (bus.aluoutpu[1:0] == 2'b00);

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q;
    logic          mem_err_q;
    logic          timeout_hit;

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            lmd_q       <= 32'h0;
            valid_out_q <= 1'b0;
            misalign_q  <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
            cnt_q       <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            valid_out_q <= 1'b0;
            misalign_q  <= 1'b0;
`ifdef MEM_LSU_TIMEOUT_EN
            mem_err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (is_mem && aligned) begin
                        mem_addr_q  <= bus.aluoutpu;
                        mem_wdata_q <= bus.B;
                        mem_we_q    <= (bus.OP_code == OP_SW);
                        mem_req_q   <= 1'b1;
`ifdef MEM_LSU_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                        state_q     <= REQ;
                    end else if (is_mem) begin
                        misalign_q <= 1'b1;
                    end
                end
                REQ: begin
                    // An ack always wins over a timeout in the same cycle.
                    if (bus.mem_ack) begin
                        if (!mem_we_q) lmd_q <= bus.mem_rdata;
                        mem_req_q   <= 1'b0;
                        valid_out_q <= 1'b1;
                        state_q     <= DONE;
                    end
`ifdef MEM_LSU_TIMEOUT_EN
                    else if (timeout_hit) begin
                        mem_req_q   <= 1'b0;
                        valid_out_q <= 1'b1;
                        mem_err_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.LMD       = lmd_q;
    assign bus.valid_out = valid_out_q;
    assign bus.misalign  = misalign_q;
    assign bus.stall     = (state_q == IDLE && is_mem && aligned) || (state_q == REQ);
`ifdef MEM_LSU_TIMEOUT_EN
    assign bus.mem_err   = mem_err_q;
`else
    assign bus.mem_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, reset/timeout sequences and random ops vs a transaction model.
// Timeout sequences are built only when MEM_LSU_TIMEOUT_EN is defined.
module tb_mem_lsu;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] lmd_model;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT(16)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] b;
        int          delay;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_we;
        logic        e_mis;
        logic [31:0] e_lmd;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One instruction through the MEM stage; the environment acks after 'delay' wait cycles.
    task automatic run_op(input logic v, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] b, input int delay, input logic [31:0] rdata,
                          input logic e_stall, input logic e_we, input logic e_mis,
                          input logic [31:0] e_lmd);
        @(negedge clk);
        bus.valid_in = v; bus.OP_code = op; bus.aluoutpu = addr; bus.B = b;
        bus.mem_ack = 1'b0;
        if (!e_stall) begin
            bus.mem_ack   = 1'($urandom);
            bus.mem_rdata = $urandom;
        end
        #1 chk("stall_accept", 32'(bus.stall), 32'(e_stall));
        @(posedge clk); #1;
        if (e_stall) begin
            chk("req_issue", 32'(bus.mem_req), 32'd1);
            chk("req_addr", bus.mem_addr, addr);
            chk("req_we", 32'(bus.mem_we), 32'(e_we));
            chk("req_wdata", bus.mem_wdata, b);
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                bus.valid_in = 1'($urandom); bus.OP_code = 6'($urandom);
                bus.aluoutpu = $urandom; bus.B = $urandom; bus.mem_rdata = $urandom;
                #1 chk("stall_wait", 32'(bus.stall), 32'd1);
                @(posedge clk); #1;
                chk("req_hold", 32'(bus.mem_req), 32'd1);
                chk("addr_hold", bus.mem_addr, addr);
                chk("wdata_hold", bus.mem_wdata, b);
                chk("we_hold", 32'(bus.mem_we), 32'(e_we));
                chk("vout_wait", 32'(bus.valid_out), 32'd0);
            end
            @(negedge clk);
            bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
            #1 chk("stall_ack", 32'(bus.stall), 32'd1);
            @(posedge clk); #1;
            chk("done_req", 32'(bus.mem_req), 32'd0);
            chk("done_vout", 32'(bus.valid_out), 32'd1);
            chk("done_err", 32'(bus.mem_err), 32'd0);
            chk("done_lmd", bus.LMD, e_lmd);
            chk("done_stall", 32'(bus.stall), 32'd0);
            @(negedge clk);
            bus.mem_ack = 1'b0; bus.valid_in = 1'b0;
            @(posedge clk); #1;
            chk("vout_pulse", 32'(bus.valid_out), 32'd0);
            chk("idle_req", 32'(bus.mem_req), 32'd0);
        end else begin
            chk("noreq", 32'(bus.mem_req), 32'd0);
            chk("novout", 32'(bus.valid_out), 32'd0);
            chk("misalign", 32'(bus.misalign), 32'(e_mis));
            chk("lmd_keep", bus.LMD, e_lmd);
            @(negedge clk);
            bus.valid_in = 1'b0; bus.mem_ack = 1'b0;
            @(posedge clk); #1;
            chk("misalign_pulse", 32'(bus.misalign), 32'd0);
            chk("lmd_keep2", bus.LMD, e_lmd);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        vecs[0] = '{1'b1, LW,       32'h0000_0010, 32'h0,          0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h1234_5678};
        vecs[1] = '{1'b1, SW,       32'h0000_0020, 32'hCAFE_F00D,  3, 32'h5555_AAAA, 1'b1, 1'b1, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, LW,       32'h0000_0013, 32'h0,          0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[3] = '{1'b1, 6'b000000, 32'h0000_0040, 32'h1111_1111, 0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b0, LW,       32'h0000_0044, 32'h0,          0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b1, SW,       32'h0000_0022, 32'h7777_7777,  0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678};
        vecs[6] = '{1'b1, LW,       32'hFFFF_FFFC, 32'h0,          2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[7] = '{1'b0, SW,       32'h0000_0050, 32'h0,          0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};

        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.OP_code = 6'h0; bus.aluoutpu = 32'h0; bus.B = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.mem_req), 32'd0);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        chk("rst_lmd", bus.LMD, 32'h0);
        chk("rst_vout", 32'(bus.valid_out), 32'd0);
        chk("rst_mis", 32'(bus.misalign), 32'd0);
        chk("rst_err", 32'(bus.mem_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[k])
            run_op(vecs[k].v, vecs[k].op, vecs[k].addr, vecs[k].b, vecs[k].delay, vecs[k].rdata,
                   vecs[k].e_stall, vecs[k].e_we, vecs[k].e_mis, vecs[k].e_lmd);

        // Reset while a request is outstanding.
        @(negedge clk);
        bus.valid_in = 1'b1; bus.OP_code = LW; bus.aluoutpu = 32'h0000_0080; bus.mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("midreq_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        bus.valid_in = 1'b0; rst_n = 1'b0;
        #1;
        chk("midreq_rst_req", 32'(bus.mem_req), 32'd0);
        chk("midreq_rst_lmd", bus.LMD, 32'h0);
        chk("midreq_rst_stall", 32'(bus.stall), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", 32'(bus.mem_req), 32'd0);
        chk("post_rst_vout", 32'(bus.valid_out), 32'd0);
        chk("post_rst_lmd", bus.LMD, 32'h0);
        run_op(1'b1, LW, 32'h0000_0084, 32'h0, 1, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0, 32'h0BAD_CAFE);
        lmd_model = 32'h0BAD_CAFE;

`ifdef MEM_LSU_TIMEOUT_EN
        begin
            int  hi;
            bit  seen;
            hi = 0; seen = 0;
            @(negedge clk);
            bus.valid_in = 1'b1; bus.OP_code = LW; bus.aluoutpu = 32'h0000_0100; bus.mem_ack = 1'b0;
            @(posedge clk); #1;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (bus.mem_req) hi++;
                if (bus.valid_out) begin
                    seen = 1;
                    chk("to_err", 32'(bus.mem_err), 32'd1);
                    chk("to_lmd", bus.LMD, lmd_model);
                end
                @(negedge clk) bus.valid_in = 1'b0;
                @(posedge clk); #1;
            end
            chk("to_seen", 32'(seen), 32'd1);
            chk("to_req_cycles", 32'(hi), 32'd16);
            chk("to_err_pulse", 32'(bus.mem_err), 32'd0);
            run_op(1'b1, LW, 32'h0000_0104, 32'h0, 15, 32'hA5A5_0016, 1'b1, 1'b0, 1'b0, 32'hA5A5_0016);
            lmd_model = 32'hA5A5_0016;
        end
`else
        run_op(1'b1, LW, 32'h0000_0104, 32'h0, 20, 32'hA5A5_0020, 1'b1, 1'b0, 1'b0, 32'hA5A5_0020);
        lmd_model = 32'hA5A5_0020;
`endif

        for (int n = 0; n < 40; n++) begin
            logic        v, is_mem, aligned;
            logic [5:0]  op;
            logic [31:0] addr, b, rdata;
            int          sel, dly;
            sel = int'($urandom_range(0, 5));
            v = (sel != 5);
            case (sel)
                0, 1, 5: op = LW;
                2:       op = SW;
                3:       op = 6'b000000;
                default: op = 6'($urandom);
            endcase
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            b = $urandom; rdata = $urandom;
            dly = int'($urandom_range(0, 6));
            is_mem  = v && (op == LW || op == SW);
            aligned = (addr % 4 == 0);
            if (is_mem && aligned && op == LW) lmd_model = rdata;
            run_op(v, op, addr, b, dly, rdata, is_mem && aligned, op == SW,
                   is_mem && !aligned, lmd_model);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
